axi_lite_regfile: RTL and testbench



---
 rtl/axi_lite_regfile_if.sv | 35 +++
 rtl/axi_lite_regfile.sv | 148 ++++++++++++++
 tb/tb_axi_lite_regfile.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite bus bundle for the register file: AW, W, B, AR and R channels.
// Ports: slave modport (register file side), master modport (interconnect/bench side).
// Parameters: ADDR_WIDTH byte-address width, DATA_WIDTH 32 or 64.
interface axi_lite_regfile_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: NUM_REGS control (RW) or status (RO) words, byte-strobed writes.
// Ports: aclk/aresetn, AXI slave bus s, reg_out (RW contents, RO slots 0), status_in (RO sources),
// wr_pulse (one-cycle strobe per successful write). One outstanding write and one outstanding read.
module axi_lite_regfile #(
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  axi_lite_regfile_if.slave              s,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int         STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int         LANE_SHIFT  = $clog2(STRB_WIDTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Readies are held low until the first edge after reset release.
  logic                  rdy_en;
  logic                  aw_full;
  logic                  w_full;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [ADDR_WIDTH-1:0] aw_idx;
  logic [ADDR_WIDTH-1:0] ar_idx;
  logic [NUM_REGS-1:0]   wr_sel;
  logic                  wr_ok;
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;

  assign s.awready = rdy_en && !aw_full && !bvalid_q;
  assign s.wready  = rdy_en && !w_full && !bvalid_q;
  assign s.arready = rdy_en && !rvalid_q;
  assign s.bvalid  = bvalid_q;
  assign s.bresp   = bresp_q;
  assign s.rvalid  = rvalid_q;
  assign s.rresp   = rresp_q;
  assign s.rdata   = rdata_q;

  assign aw_hs  = s.awvalid && s.awready;
  assign w_hs   = s.wvalid && s.wready;
  assign ar_hs  = s.arvalid && s.arready;
  assign commit = aw_full && w_full;

  // Byte-offset bits below the word size are dropped.
  assign aw_idx = aw_addr_q >> LANE_SHIFT;
  assign ar_idx = s.araddr >> LANE_SHIFT;

  // Address decode; an index with no matching slot stays unselected and answers SLVERR.
  always_comb begin
    wr_sel  = '0;
    wr_ok   = 1'b0;
    rd_hit  = 1'b0;
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx == ADDR_WIDTH'(i) && !RO_MASK[i]) begin
        wr_sel[i] = 1'b1;
        wr_ok     = 1'b1;
      end
      if (ar_idx == ADDR_WIDTH'(i)) begin
        rd_hit  = 1'b1;
        rd_data = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!RO_MASK[i]) reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end
  end

  // Write path: AW and W buffers fill independently; commit once both are held.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_en    <= 1'b0;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wr_pulse  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      rdy_en   <= 1'b1;
      wr_pulse <= '0;
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= s.awaddr;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= s.wdata;
        w_strb_q <= s.wstrb;
      end
      if (commit) begin
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        wr_pulse <= wr_sel;
        for (int i = 0; i < NUM_REGS; i++) begin
          for (int k = 0; k < STRB_WIDTH; k++) begin
            if (wr_sel[i] && w_strb_q[k]) regs[i][k*8 +: 8] <= w_data_q[k*8 +: 8];
          end
        end
      end else if (bvalid_q && s.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read path: data is captured at the AR handshake, so a commit on the same
  // edge is not yet visible and the pre-write value is returned.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      rdata_q  <= rd_data;
    end else if (rvalid_q && s.rready) begin
      rvalid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_lite_regfile.sv
// Randomized self-checking bench for axi_lite_regfile against an array-based reference model.
// Covers reset, strobed writes, W-before-AW, RO/out-of-range errors, backpressure, collision, mid-write reset.
module tb_axi_lite_regfile;
  localparam int             AW    = 8;
  localparam int             DW    = 32;
  localparam int             NR    = 8;
  localparam logic [NR-1:0]  RO    = 8'h04;
  localparam int             LIMIT = 40;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  logic [NR*DW-1:0] reg_out;
  logic [NR*DW-1:0] status_in;
  logic [NR-1:0]    wr_pulse;

  axi_lite_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_regfile #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .s(bus),
    .reg_out(reg_out), .status_in(status_in), .wr_pulse(wr_pulse)
  );

  always #5 aclk = ~aclk;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] exp_regs [NR];
  logic [NR-1:0] ro_mask = RO;
  int            pulse_cnt [NR];

  always @(negedge aclk) begin
    for (int i = 0; i < NR; i++) if (wr_pulse[i]) pulse_cnt[i]++;
  end

  task automatic check_eq(input string tag, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic note_timeout(input string tag);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no response within %0d cycles", tag, LIMIT);
  endtask

  function automatic int total_pulses();
    int t = 0;
    for (int i = 0; i < NR; i++) t += pulse_cnt[i];
    return t;
  endfunction

  function automatic logic [NR*DW-1:0] exp_flat();
    logic [NR*DW-1:0] v = '0;
    for (int i = 0; i < NR; i++) if (!ro_mask[i]) v[i*DW +: DW] = exp_regs[i];
    return v;
  endfunction

  // Reference model: word index is the byte address divided by 4.
  task automatic model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [NR-1:0] sel);
    int idx;
    idx  = int'(addr) / 4;
    sel  = '0;
    resp = 2'b10;
    if (idx < NR && !ro_mask[idx]) begin
      resp     = 2'b00;
      sel[idx] = 1'b1;
      for (int k = 0; k < 4; k++) if (strb[k]) exp_regs[idx][8*k +: 8] = data[8*k +: 8];
    end
  endtask

  task automatic model_read(input logic [AW-1:0] addr, output logic [DW-1:0] data, output logic [1:0] resp);
    int idx;
    idx = int'(addr) / 4;
    if (idx >= NR) begin
      data = '0;
      resp = 2'b10;
    end else begin
      data = ro_mask[idx] ? status_in[idx*DW +: DW] : exp_regs[idx];
      resp = 2'b00;
    end
  endtask

  task automatic send_aw(input logic [AW-1:0] addr, input int dly);
    int n = 0;
    repeat (dly) begin @(posedge aclk); #1; end
    bus.awaddr  = addr;
    bus.awvalid = 1'b1;
    while (!bus.awready && n < LIMIT) begin @(posedge aclk); #1; n++; end
    if (n >= LIMIT) note_timeout("aw_handshake");
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] data, input logic [3:0] strb, input int dly);
    int n = 0;
    repeat (dly) begin @(posedge aclk); #1; end
    bus.wdata  = data;
    bus.wstrb  = strb;
    bus.wvalid = 1'b1;
    while (!bus.wready && n < LIMIT) begin @(posedge aclk); #1; n++; end
    if (n >= LIMIT) note_timeout("w_handshake");
    @(posedge aclk); #1;
    bus.wvalid = 1'b0;
  endtask

  task automatic wait_b(input int b_dly, output logic [1:0] resp, output int lat, output logic [NR-1:0] pl);
    logic stable = 1'b1;
    lat = 0;
    while (!bus.bvalid && lat < LIMIT) begin @(posedge aclk); #1; lat++; end
    if (lat >= LIMIT) note_timeout("b_valid");
    resp = bus.bresp;
    pl   = wr_pulse;
    repeat (b_dly) begin
      @(posedge aclk); #1;
      if (!bus.bvalid || bus.bresp !== resp || bus.awready || bus.wready) stable = 1'b0;
    end
    if (b_dly > 0) check_eq("b_hold_stable", stable, 1'b1);
    bus.bready = 1'b1;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    check_eq("b_clear", bus.bvalid, 1'b0);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int r_dly, output logic [DW-1:0] data,
                          output logic [1:0] resp);
    int   n = 0;
    logic stable = 1'b1;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    while (!bus.arready && n < LIMIT) begin @(posedge aclk); #1; n++; end
    if (n >= LIMIT) note_timeout("ar_handshake");
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    check_eq("r_latency", bus.rvalid, 1'b1);
    data = bus.rdata;
    resp = bus.rresp;
    repeat (r_dly) begin
      @(posedge aclk); #1;
      if (!bus.rvalid || bus.rdata !== data || bus.rresp !== resp || bus.arready) stable = 1'b0;
    end
    if (r_dly > 0) check_eq("r_hold_stable", stable, 1'b1);
    bus.rready = 1'b1;
    @(posedge aclk); #1;
    bus.rready = 1'b0;
    check_eq("r_clear", bus.rvalid, 1'b0);
  endtask

  // Full write with independent AW/W delays; mid > 0 checks for no early commit after mid cycles.
  task automatic write_txn(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input int ad, input int wd, input int bd, input int mid);
    logic [1:0]       eresp, resp;
    logic [NR-1:0]    esel, pl;
    logic [NR*DW-1:0] pre;
    int               p0, lat;
    pre = exp_flat();
    p0  = total_pulses();
    model_write(addr, data, strb, eresp, esel);
    fork
      send_aw(addr, ad);
      send_w(data, strb, wd);
      if (mid > 0) begin
        repeat (mid) begin @(posedge aclk); #1; end
        check_eq({tag, "_no_early_b"}, bus.bvalid, 1'b0);
        check_eq({tag, "_no_early_reg"}, reg_out, pre);
      end
    join
    check_eq({tag, "_b_before_commit"}, bus.bvalid, 1'b0);
    wait_b(bd, resp, lat, pl);
    check_eq({tag, "_b_latency"}, lat, 1);
    check_eq({tag, "_pulse_at_b"}, pl, esel);
    check_eq({tag, "_bresp"}, resp, eresp);
    check_eq({tag, "_reg_out"}, reg_out, exp_flat());
    check_eq({tag, "_pulse_count"}, total_pulses() - p0, (esel != 0) ? 1 : 0);
  endtask

  task automatic read_txn(input string tag, input logic [AW-1:0] addr, input int rd);
    logic [DW-1:0] ed, d;
    logic [1:0]    er, r;
    model_read(addr, ed, er);
    axi_read(addr, rd, d, r);
    check_eq({tag, "_rdata"}, d, ed);
    check_eq({tag, "_rresp"}, r, er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] ed, d;
    logic [1:0]    er, r, eb, b;
    logic [NR-1:0] esel, pl;
    int            lat;

    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    status_in = '0;
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;

    repeat (3) @(posedge aclk);
    #1;
    check_eq("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
    check_eq("rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
    check_eq("rst_resps", {bus.bresp, bus.rresp}, 4'h0);
    check_eq("rst_rdata", bus.rdata, 0);
    check_eq("rst_reg_out", reg_out, 0);
    check_eq("rst_wr_pulse", wr_pulse, 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check_eq("readies_up", {bus.awready, bus.wready, bus.arready}, 3'b111);

    // Full-word write then read back.
    write_txn("t1", 8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
    check_eq("t1_pulse_reg1", pulse_cnt[1], 1);
    read_txn("t1_rd", 8'h04, 0);

    // W first, AW three cycles later, sparse strobe over a preloaded word.
    write_txn("t2_pre", 8'h0C, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0);
    write_txn("t2", 8'h0C, 32'h11223344, 4'h5, 3, 0, 0, 3);
    check_eq("t2_value", reg_out[3*DW +: DW], 32'hFF22FF44);

    // Read-only status slot.
    status_in[2*DW +: DW] = 32'hCAFE0001;
    read_txn("t3_ro_rd", 8'h08, 0);
    write_txn("t3_ro_wr", 8'h08, 32'h12345678, 4'hF, 0, 0, 0, 0);

    // Out of range index NUM_REGS.
    write_txn("t4_oor_wr", 8'h20, 32'hA5A5A5A5, 4'hF, 1, 0, 0, 0);
    read_txn("t4_oor_rd", 8'h20, 0);

    // Zero strobe still counts as a write.
    write_txn("t4b_nostrb", 8'h04, 32'h0BADF00D, 4'h0, 0, 1, 0, 0);

    // Backpressure on both response channels.
    write_txn("t5_bp", 8'h10, 32'h5555AAAA, 4'hF, 0, 0, 5, 0);
    read_txn("t5_bp_rd", 8'h10, 5);

    // Read handshake on the same edge as a commit to the same register.
    write_txn("t6_pre", 8'h00, 32'h01020304, 4'hF, 0, 0, 0, 0);
    model_read(8'h00, ed, er);
    model_write(8'h00, 32'hF0E0D0C0, 4'hF, eb, esel);
    fork
      send_aw(8'h00, 0);
      send_w(32'hF0E0D0C0, 4'hF, 0);
    join
    axi_read(8'h00, 0, d, r);
    check_eq("t6_coll_old_value", d, ed);
    check_eq("t6_coll_rresp", r, er);
    wait_b(0, b, lat, pl);
    check_eq("t6_coll_bresp", b, eb);
    check_eq("t6_coll_reg_out", reg_out, exp_flat());

    // Reset while a write response is pending, with a stray AW left behind.
    fork
      send_aw(8'h14, 0);
      send_w(32'h77777777, 4'hF, 0);
    join
    @(posedge aclk); #1;
    check_eq("t7_bvalid_before_rst", bus.bvalid, 1'b1);
    aresetn = 1'b0;
    #1;
    check_eq("t7_rst_bvalid", bus.bvalid, 1'b0);
    check_eq("t7_rst_reg_out", reg_out, 0);
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;
    @(posedge aclk); #2;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    send_aw(8'h18, 0);
    aresetn = 1'b0;
    #2;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    write_txn("t7_after_rst", 8'h1C, 32'h13579BDF, 4'hF, 0, 2, 0, 0);

    // Random traffic.
    for (int it = 0; it < 40; it++) begin
      logic [AW-1:0] addr;
      for (int i = 0; i < NR; i++) status_in[i*DW +: DW] = $urandom();
      addr = AW'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
      write_txn("rnd_wr", addr, $urandom(), 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 0);
      addr = AW'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
      read_txn("rnd_rd", addr, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
